mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller and responder for the two memory initiators, the MEM stage (loads/stores) and the I-cache (instruction fetch).
- Arbitrates between them and serializes each 1/2/4-byte request onto the byte-wide RAM/IO bus.
- Returns read data little-endian assembled, with a one-cycle completion pulse per requester.
- Drives busy flags so the losing requester stalls.

Parameters:
- ADDR_W, 32, width of request and RAM addresses.
- IO_ADDR, 32'h30000, lowest address treated as memory-mapped IO.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- MEM_E_in  input  1  MEM request valid (level, held until MEM_dataE_out)
- MEM_rw_in  input  1  0=READ, 1=WRITE
- MEM_addr_in  input  ADDR_W  byte address
- MEM_data_in  input  32  store data, low bytes significant
- MEM_len_in  input  3  byte count: 1, 2 or 4
- IC_E_in  input  1  I-cache fetch request valid (level)
- IC_addr_in  input  ADDR_W  fetch address, always 4 bytes
- ram_din_in  input  8  byte returned by RAM, one cycle after address
- ram_dout_out  output  8  byte to write
- ram_a_out  output  ADDR_W  RAM address
- ram_wr_out  output  1  1=write this cycle
- busyMEM_out  output  1  controller serving MEM
- busyICache_out  output  1  controller serving I-cache
- MEM_dataE_out  output  1  one-cycle completion pulse to MEM (load or store)
- MEM_data_out  output  32  load data, zero-extended to 32 bits
- IC_dataE_out  output  1  one-cycle completion pulse to I-cache
- IC_data_out  output  32  fetched instruction word

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counters 0, all outputs 0. ram_wr_out=0 immediately, so a partial write is abandoned.
- States: IDLE, RD, WR, DONE.
- IDLE arbitration:
  - MEM_E_in has priority over IC_E_in.
  - Latch owner, rw, addr, len and data; clear byte counter cnt and assembly register.
  - Go to RD or WR. Assert the matching busy flag from the next cycle until DONE exits.
  - A request seen in IDLE is not busy-flagged that cycle; the busy flag rises the next cycle.
- RD, len n:
  - Cycle k (k=0..n-1) drives ram_a_out=addr+k, ram_wr_out=0.
  - The byte for address k is captured from ram_din_in in cycle k+1 into bits [8k+7:8k].
  - After capturing byte n-1 (cycle n), go to DONE.
  - Total latency from the first busy cycle to the pulse is n+2 cycles.
- WR, len n:
  - Cycle k drives ram_a_out=addr+k, ram_dout_out=data[8k+7:8k], ram_wr_out=1.
  - After byte n-1, go to DONE.
- DONE:
  - Pulse the owner's dataE_out for exactly one cycle, with data_out valid that cycle.
  - Clear busy and return to IDLE. New arbitration happens no earlier than the next cycle.
  - data_out holds its value until the next completion.
- Requester drop mid-operation:
  - If the owner deasserts E during RD (e.g. I-cache flush), abort to IDLE next cycle. No pulse, busy cleared.
  - Writes are never aborted; they run to DONE regardless.
- Illegal len (0, 3, >4): treat as 4.
- Address arithmetic wraps modulo 2^ADDR_W.
- ram_a_out=0 and ram_dout_out=0 whenever the controller is not driving a transfer.
- Simultaneous MEM and IC requests in IDLE: MEM is served, and busyMEM_out rises the next cycle. The I-cache keeps requesting and is served after DONE.

Optional Feature:
- MEM_CTRL_IO_FULL_STALL_EN
- Defined:
  - Adds input io_buffer_full_in (1 bit).
  - A WR byte whose address is >= IO_ADDR is not issued while io_buffer_full_in=1: ram_wr_out=0, cnt and state hold.
  - The byte is issued on the first cycle the input is 0.
- Undefined: port absent; IO writes proceed unconditionally.

Decomposition:
- Shared defines header: READ/WRITE codes, Enable/Disable, Busy, ZERO32, and state encodings for IDLE/RD/WR/DONE.
- No sub-module; one sequential process plus output decode.

Test Plan:
- Reset mid-write: reset during WR byte 1 of SW -> ram_wr_out=0 the same cycle; all outputs 0; state IDLE.
- LW read: MEM READ addr 0x100 len 4, RAM returns 0x11,0x22,0x33,0x44 -> ram_a_out 0x100..0x103 on consecutive cycles; MEM_dataE_out pulses once with MEM_data_out=0x44332211; busyMEM_out high for the 5 cycles before the pulse.
- SH write: MEM WRITE addr 0x2000 data 0xDEADBEEF len 2 -> two write cycles, (0x2000, 0xEF) and (0x2001, 0xBE); then a pulse; no third write.
- Arbitration: IC_E_in and MEM_E_in (LB len 1) rise together -> MEM is served first, busyICache_out stays 0; the I-cache fetch of 0x0 starts after DONE, and IC_dataE_out pulses with the assembled word.
- Fetch abort: IC_E_in drops during RD cnt=2 -> next cycle IDLE, busyICache_out=0, no IC_dataE_out pulse.
- Optional feature (with MEM_CTRL_IO_FULL_STALL_EN): SB to 0x30000 with io_buffer_full_in=1 for 3 cycles -> ram_wr_out stays 0 for those 3 cycles, then one write of the byte, then a pulse.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared codes, state encoding and byte helpers for mem_ctrl.
//   READ/WRITE    - MEM_rw_in encoding
//   ENABLE/DISABLE, BUSY, ZERO32 - common constants
//   state_t       - controller states IDLE/RD/WR/DONE
//   norm_len      - maps a requested byte count onto 1, 2 or 4
//   get_byte      - extracts byte lane idx of a 32-bit word
//   put_byte      - replaces byte lane idx of a 32-bit word
package mem_ctrl_pkg;

  localparam logic        READ      = 1'b0;
  localparam logic        WRITE     = 1'b1;
  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic        BUSY      = 1'b1;
  localparam logic [31:0] ZERO32    = 32'h0000_0000;
  localparam logic        OWNER_MEM = 1'b0;
  localparam logic        OWNER_IC  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Anything other than 1 or 2 bytes is served as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      3'd1:    norm_len = 3'd1;
      3'd2:    norm_len = 3'd2;
      default: norm_len = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    get_byte = d[7:0];
      2'd1:    get_byte = d[15:8];
      2'd2:    get_byte = d[23:16];
      default: get_byte = d[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [1:0] idx,
                                           input logic [7:0] b);
    put_byte = d;
    case (idx)
      2'd0:    put_byte[7:0]   = b;
      2'd1:    put_byte[15:8]  = b;
      2'd2:    put_byte[23:16] = b;
      default: put_byte[31:24] = b;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the MEM stage and the I-cache onto a byte-wide RAM/IO
// bus, serialising 1/2/4-byte transfers and assembling reads little-endian.
// Ports:
//   clk_in, rst_in (async, active-high)
//   MEM_E_in/MEM_rw_in/MEM_addr_in/MEM_data_in/MEM_len_in - MEM request (level)
//   IC_E_in/IC_addr_in                                    - 4-byte fetch (level)
//   ram_din_in  - read byte, one cycle after its address
//   ram_dout_out/ram_a_out/ram_wr_out - byte bus to RAM/IO
//   busyMEM_out/busyICache_out        - which requester is being served
//   MEM_dataE_out/MEM_data_out, IC_dataE_out/IC_data_out - completion pulse + data
// Optional build macro MEM_CTRL_IO_FULL_STALL_EN adds io_buffer_full_in: a write
// byte at or above IO_ADDR waits while the IO buffer reports full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(32'h30000)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              MEM_E_in,
  input  logic              MEM_rw_in,
  input  logic [ADDR_W-1:0] MEM_addr_in,
  input  logic [31:0]       MEM_data_in,
  input  logic [2:0]        MEM_len_in,
  input  logic              IC_E_in,
  input  logic [ADDR_W-1:0] IC_addr_in,
`ifdef MEM_CTRL_IO_FULL_STALL_EN
  input  logic              io_buffer_full_in,
`endif
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic              busyMEM_out,
  output logic              busyICache_out,
  output logic              MEM_dataE_out,
  output logic [31:0]       MEM_data_out,
  output logic              IC_dataE_out,
  output logic [31:0]       IC_data_out
);

  state_t            r_state;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_len;
  logic [31:0]       r_data;
  logic [2:0]        r_cnt;
  logic [31:0]       r_asm;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_dout;
  logic              r_ram_wr;
  logic              r_busy_mem;
  logic              r_busy_ic;
  logic              r_mem_de;
  logic [31:0]       r_mem_data;
  logic              r_ic_de;
  logic [31:0]       r_ic_data;

  logic              w_owner_e;
  logic              w_io_addr;
  logic              w_stall;
  logic [2:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_next_addr;
  logic [31:0]       w_asm_next;

  // Owner request level, next byte address, assembly update and IO stall.
  always_comb begin
    w_owner_e   = (r_owner == OWNER_MEM) ? MEM_E_in : IC_E_in;
    w_cnt_next  = r_cnt + 3'd1;
    w_next_addr = r_addr + ADDR_W'(w_cnt_next);
    // In cycle cnt the bus returns the byte addressed in cycle cnt-1.
    w_asm_next  = put_byte(r_asm, r_cnt[1:0] - 2'd1, ram_din_in);
    w_io_addr   = (r_ram_a >= IO_ADDR);
`ifdef MEM_CTRL_IO_FULL_STALL_EN
    w_stall     = r_ram_wr & w_io_addr & io_buffer_full_in;
`else
    // IO writes never wait in this build.
    w_stall     = r_ram_wr & w_io_addr & DISABLE;
`endif
  end

  // Controller FSM with registered bus and requester outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_owner    <= OWNER_MEM;
      r_addr     <= '0;
      r_len      <= 3'd0;
      r_data     <= ZERO32;
      r_cnt      <= 3'd0;
      r_asm      <= ZERO32;
      r_ram_a    <= '0;
      r_ram_dout <= 8'h00;
      r_ram_wr   <= 1'b0;
      r_busy_mem <= 1'b0;
      r_busy_ic  <= 1'b0;
      r_mem_de   <= 1'b0;
      r_mem_data <= ZERO32;
      r_ic_de    <= 1'b0;
      r_ic_data  <= ZERO32;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_de <= 1'b0;
          r_ic_de  <= 1'b0;
          r_cnt    <= 3'd0;
          r_asm    <= ZERO32;
          if (MEM_E_in) begin
            r_owner    <= OWNER_MEM;
            r_addr     <= MEM_addr_in;
            r_len      <= norm_len(MEM_len_in);
            r_data     <= MEM_data_in;
            r_busy_mem <= BUSY;
            r_ram_a    <= MEM_addr_in;
            if (MEM_rw_in == WRITE) begin
              r_state    <= S_WR;
              r_ram_dout <= MEM_data_in[7:0];
              r_ram_wr   <= ENABLE;
            end else begin
              r_state    <= S_RD;
            end
          end else if (IC_E_in) begin
            r_owner   <= OWNER_IC;
            r_addr    <= IC_addr_in;
            r_len     <= 3'd4;
            r_data    <= ZERO32;
            r_busy_ic <= BUSY;
            r_ram_a   <= IC_addr_in;
            r_state   <= S_RD;
          end
        end

        S_RD: begin
          if (!w_owner_e) begin
            // Requester withdrew (e.g. flush): drop the fetch silently.
            r_state    <= S_IDLE;
            r_busy_mem <= 1'b0;
            r_busy_ic  <= 1'b0;
            r_ram_a    <= '0;
          end else begin
            if (r_cnt != 3'd0) begin
              r_asm <= w_asm_next;
            end
            if (r_cnt == r_len) begin
              r_state    <= S_DONE;
              r_busy_mem <= 1'b0;
              r_busy_ic  <= 1'b0;
              r_ram_a    <= '0;
              if (r_owner == OWNER_MEM) begin
                r_mem_de   <= 1'b1;
                r_mem_data <= w_asm_next;
              end else begin
                r_ic_de   <= 1'b1;
                r_ic_data <= w_asm_next;
              end
            end else begin
              r_cnt   <= w_cnt_next;
              // Last cycle only collects the final byte; no address is driven.
              r_ram_a <= (w_cnt_next < r_len) ? w_next_addr : '0;
            end
          end
        end

        S_WR: begin
          if (!w_stall) begin
            if (w_cnt_next == r_len) begin
              r_state    <= S_DONE;
              r_busy_mem <= 1'b0;
              r_ram_wr   <= 1'b0;
              r_ram_a    <= '0;
              r_ram_dout <= 8'h00;
              r_mem_de   <= 1'b1;
            end else begin
              r_cnt      <= w_cnt_next;
              r_ram_a    <= w_next_addr;
              r_ram_dout <= get_byte(r_data, w_cnt_next[1:0]);
            end
          end
        end

        S_DONE: begin
          r_state  <= S_IDLE;
          r_mem_de <= 1'b0;
          r_ic_de  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_a_out      = r_ram_a;
  assign ram_dout_out   = r_ram_dout;
  // Gated so a full IO buffer suppresses the strobe in the same cycle.
  assign ram_wr_out     = r_ram_wr & ~w_stall;
  assign busyMEM_out    = r_busy_mem;
  assign busyICache_out = r_busy_ic;
  assign MEM_dataE_out  = r_mem_de;
  assign MEM_data_out   = r_mem_data;
  assign IC_dataE_out   = r_ic_de;
  assign IC_data_out    = r_ic_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte RAM model answers the
// bus; a transaction-level reference (byte map + latency rules) predicts results.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        MEM_E, MEM_rw, IC_E, io_full;
  logic [31:0] MEM_addr, MEM_data, IC_addr;
  logic [2:0]  MEM_len;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out, busyMEM_out, busyICache_out;
  logic        MEM_dataE_out, IC_dataE_out;
  logic [31:0] MEM_data_out, IC_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
`ifdef MEM_CTRL_IO_FULL_STALL_EN
    .io_buffer_full_in(io_full),
`endif
    .clk_in(clk), .rst_in(rst_in),
    .MEM_E_in(MEM_E), .MEM_rw_in(MEM_rw), .MEM_addr_in(MEM_addr),
    .MEM_data_in(MEM_data), .MEM_len_in(MEM_len),
    .IC_E_in(IC_E), .IC_addr_in(IC_addr),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout_out), .ram_a_out(ram_a_out),
    .ram_wr_out(ram_wr_out), .busyMEM_out(busyMEM_out), .busyICache_out(busyICache_out),
    .MEM_dataE_out(MEM_dataE_out), .MEM_data_out(MEM_data_out),
    .IC_dataE_out(IC_dataE_out), .IC_data_out(IC_data_out)
  );

  // Byte RAM: unwritten bytes read back a fixed address hash.
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    ram_din <= ram_mem.exists(ram_a_out) ? ram_mem[ram_a_out] : dflt(ram_a_out);
    if (ram_wr_out) ram_mem[ram_a_out] = ram_dout_out;
  end

  // Reference model: transfer size, memory image, expected timing.
  function automatic int model_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one request to completion, recording what the bus and flags did.
  task automatic do_txn(input bit is_ic, input bit rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] len,
                        output int lat, output logic [31:0] rdata, output int busy_cnt,
                        output int other_cnt, output int wr_cnt, output bit addr_ok,
                        output bit post_ok);
    int n;
    n = model_len(len);
    lat = -1; rdata = 32'h0; busy_cnt = 0; other_cnt = 0; wr_cnt = 0;
    addr_ok = 1'b1; post_ok = 1'b1;
    if (is_ic) begin
      IC_E = 1'b1; IC_addr = addr;
    end else begin
      MEM_E = 1'b1; MEM_rw = rw; MEM_addr = addr; MEM_data = data; MEM_len = len;
    end
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge clk);
      if (is_ic ? busyICache_out : busyMEM_out) busy_cnt++;
      if (is_ic ? (busyMEM_out | MEM_dataE_out) : (busyICache_out | IC_dataE_out)) other_cnt++;
      if (ram_wr_out) wr_cnt++;
      if (i <= n && ram_a_out !== addr + 32'(i - 1)) addr_ok = 1'b0;
      if (is_ic ? IC_dataE_out : MEM_dataE_out) begin
        lat = i;
        rdata = is_ic ? IC_data_out : MEM_data_out;
        if (ram_a_out !== 32'h0 || ram_wr_out) addr_ok = 1'b0;
        MEM_E = 1'b0; IC_E = 1'b0;
      end
    end
    MEM_E = 1'b0; IC_E = 1'b0;
    @(negedge clk);
    if (MEM_dataE_out || IC_dataE_out || busyMEM_out || busyICache_out) post_ok = 1'b0;
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, busy_cnt, other_cnt, wr_cnt, n, exp_lat;
    int mem_pi, ic_pi, ic_early, pulses, wr_seen;
    logic [31:0] rdata, mem_d, ic_d, addr, data;
    logic [2:0] len;
    bit addr_ok, post_ok, is_ic, rw, b1, mem_ok;

    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, busy_cnt, other_cnt, wr_cnt, n, exp_lat;
    int mem_pi, ic_pi, ic_early, pulses, wr_seen;
    logic [31:0] rdata, mem_d, ic_d, addr, data;
    logic [2:0] len;
    bit addr_ok, post_ok, is_ic, rw, b1, mem_ok;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         3'd4, 32'h4433_2211, 6, 0};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         3'd2, 32'h0000_2211, 4, 0};
    vecs[2] = '{1'b0, 32'h0000_0102, 32'h0,         3'd1, 32'h0000_0033, 3, 0};
    vecs[3] = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'd2, 32'h0,         3, 2};
    vecs[4] = '{1'b0, 32'h0000_2000, 32'h0,         3'd4, 32'h7978_BEEF, 6, 0};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         3'd3, 32'h4433_2211, 6, 0};
    vecs[6] = '{1'b0, 32'h0000_0100, 32'h0,         3'd0, 32'h4433_2211, 6, 0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0A0B_0C0D, 3'd7, 32'h0,         5, 4};
    vecs[8] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         3'd4, 32'h0B0C_0D5B, 6, 0};

    ram_mem[32'h100] = 8'h11; ram_mem[32'h101] = 8'h22;
    ram_mem[32'h102] = 8'h33; ram_mem[32'h103] = 8'h44;
    ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22;
    ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;

    rst_in = 1'b1; MEM_E = 1'b0; MEM_rw = 1'b0; MEM_addr = 32'h0; MEM_data = 32'h0;
    MEM_len = 3'd0; IC_E = 1'b0; IC_addr = 32'h0; io_full = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ram_a", ram_a_out, 0);
    check("rst_ram_dout", ram_dout_out, 0);
    check("rst_ram_wr", ram_wr_out, 0);
    check("rst_busy_mem", busyMEM_out, 0);
    check("rst_busy_ic", busyICache_out, 0);
    check("rst_mem_de", MEM_dataE_out, 0);
    check("rst_mem_data", MEM_data_out, 0);
    check("rst_ic_de", IC_dataE_out, 0);
    check("rst_ic_data", IC_data_out, 0);
    rst_in = 1'b0;

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    MEM_E = 1'b1; MEM_rw = 1'b1; MEM_addr = 32'h500; MEM_data = 32'h1234_5678; MEM_len = 3'd4;
    @(negedge clk);
    @(negedge clk);
    check("sw_byte1_wr", ram_wr_out, 1);
    check("sw_byte1_addr", ram_a_out, 32'h501);
    rst_in = 1'b1;
    #1;
    check("rstmid_ram_wr", ram_wr_out, 0);
    check("rstmid_ram_a", ram_a_out, 0);
    check("rstmid_busy_mem", busyMEM_out, 0);
    check("rstmid_ram_dout", ram_dout_out, 0);
    MEM_E = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    check("rstmid_byte1_unwritten", ram_mem.exists(32'h501), 0);
    check("rstmid_byte0_written", ram_mem[32'h500], 8'h78);
    @(negedge clk);

    // Directed vector table; also confirms IDLE after the reset above.
    for (int v = 0; v < 9; v++) begin
      do_txn(1'b0, vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].len,
             lat, rdata, busy_cnt, other_cnt, wr_cnt, addr_ok, post_ok);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_busy", v), busy_cnt, vecs[v].exp_lat - 1);
      check($sformatf("vec%0d_wr", v), wr_cnt, vecs[v].exp_wr);
      check($sformatf("vec%0d_addr", v), addr_ok, 1);
      check($sformatf("vec%0d_post", v), post_ok, 1);
      if (vecs[v].rw) model_write(vecs[v].addr, vecs[v].data, model_len(vecs[v].len));
      else check($sformatf("vec%0d_data", v), rdata, vecs[v].exp_data);
    end
    check("sh_byte0", ram_mem[32'h2000], 8'hEF);
    check("sh_byte1", ram_mem[32'h2001], 8'hBE);
    check("sh_no_third", ram_mem.exists(32'h2002), 0);
    check("wrap_byte", ram_mem[32'h0000_0002], 8'h0A);

    // Simultaneous requests: MEM first, then the fetch of 0x0.
    MEM_E = 1'b1; MEM_rw = 1'b0; MEM_addr = 32'h102; MEM_len = 3'd1;
    IC_E = 1'b1; IC_addr = 32'h0;
    mem_pi = -1; ic_pi = -1; ic_early = 0; b1 = 1'b0; mem_d = 32'h0; ic_d = 32'h0;
    for (int i = 1; i <= 20 && ic_pi < 0; i++) begin
      @(negedge clk);
      if (i == 1) b1 = busyMEM_out;
      if (mem_pi < 0 && busyICache_out) ic_early++;
      if (MEM_dataE_out) begin mem_pi = i; mem_d = MEM_data_out; MEM_E = 1'b0; end
      if (IC_dataE_out) begin ic_pi = i; ic_d = IC_data_out; IC_E = 1'b0; end
    end
    MEM_E = 1'b0; IC_E = 1'b0;
    check("arb_busy_mem_first", b1, 1);
    check("arb_ic_not_busy", ic_early, 0);
    check("arb_mem_pulse_at", mem_pi, 3);
    check("arb_mem_data", mem_d, 32'h33);
    check("arb_ic_pulse_at", ic_pi, 10);
    check("arb_ic_data", ic_d, model_read(32'h0, 4));
    @(negedge clk);

    // Fetch withdrawn while cnt=2 (address 0x42 on the bus).
    IC_E = 1'b1; IC_addr = 32'h40;
    repeat (3) @(negedge clk);
    check("abort_pre_addr", ram_a_out, 32'h42);
    check("abort_pre_busy", busyICache_out, 1);
    IC_E = 1'b0;
    @(negedge clk);
    check("abort_busy_clr", busyICache_out, 0);
    check("abort_ram_a", ram_a_out, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (IC_dataE_out || busyICache_out) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", pulses, 0);

`ifdef MEM_CTRL_IO_FULL_STALL_EN
    // Store byte to IO while the buffer is full for three cycles.
    io_full = 1'b1;
    MEM_E = 1'b1; MEM_rw = 1'b1; MEM_addr = 32'h30000; MEM_data = 32'h0000_00AB; MEM_len = 3'd1;
    wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ram_wr_out) wr_seen++;
    end
    @(posedge clk);
    #1 io_full = 1'b0;
    @(negedge clk);
    check("io_stall_no_wr", wr_seen, 0);
    check("io_wr", ram_wr_out, 1);
    check("io_addr", ram_a_out, 32'h30000);
    check("io_dout", ram_dout_out, 8'hAB);
    @(negedge clk);
    check("io_pulse", MEM_dataE_out, 1);
    MEM_E = 1'b0;
    model_write(32'h30000, 32'hAB, 1);
    @(negedge clk);
`endif

    // Random traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      is_ic = ($urandom_range(0, 3) == 0);
      rw    = is_ic ? 1'b0 : 1'($urandom_range(0, 1));
      len   = is_ic ? 3'd4 : 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'h1000 + 32'($urandom_range(0, 31));
      data  = $urandom;
      n = model_len(len);
      exp_lat = rw ? n + 1 : n + 2;
      do_txn(is_ic, rw, addr, data, len, lat, rdata, busy_cnt, other_cnt, wr_cnt,
             addr_ok, post_ok);
      check($sformatf("rnd%0d_lat", t), lat, exp_lat);
      check($sformatf("rnd%0d_busy", t), busy_cnt, exp_lat - 1);
      check($sformatf("rnd%0d_other", t), other_cnt, 0);
      check($sformatf("rnd%0d_wr", t), wr_cnt, rw ? n : 0);
      check($sformatf("rnd%0d_addr", t), addr_ok, 1);
      check($sformatf("rnd%0d_post", t), post_ok, 1);
      if (rw) begin
        model_write(addr, data, n);
        mem_ok = 1'b1;
        for (int k = 0; k < n; k++)
          if (!ram_mem.exists(addr + 32'(k)) || ram_mem[addr + 32'(k)] !== ref_rd(addr + 32'(k)))
            mem_ok = 1'b0;
        check($sformatf("rnd%0d_mem", t), mem_ok, 1);
      end else begin
        check($sformatf("rnd%0d_data", t), rdata, model_read(addr, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
